// File: rtl/spawn_gen.sv
// spawn_gen: periodic obstacle spawner that draws LFSR values, maps them to a bounded gap position
// and offers it over valid/ready. Rev 1.0
`default_nettype none

module spawn_gen #(
  parameter int unsigned PERIOD     = 60,
  parameter int unsigned GAP_MIN    = 4,
  parameter int unsigned GAP_RANGE  = 20,
  parameter int unsigned MAX_REDRAW = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       tick_i,
  input  logic [4:0] rand_i,
  output logic       next_o,
  output logic       spawn_valid_o,
  input  logic       spawn_ready_i,
  output logic [5:0] spawn_pos_o,
  output logic [7:0] spawn_count_o,
  output logic       overrun_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    DRAW    = 3'd2,
    EVAL    = 3'd3,
    PRESENT = 3'd4
  } state_t;

  localparam logic [7:0] PERIOD_V     = 8'(PERIOD);
  localparam logic [5:0] GAP_MIN_V    = 6'(GAP_MIN);
  localparam logic [5:0] RANGE_V      = 6'(GAP_RANGE);
  localparam logic [7:0] MAX_REDRAW_V = 8'(MAX_REDRAW);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] period_cnt;
  logic [7:0] redraw_cnt;
  logic       expire;
  logic       handshake;
  logic       accept;
  logic       can_redraw;
  logic [5:0] rand_ext;
  logic [5:0] offset;

  assign rand_ext   = {1'b0, rand_i};
  assign expire     = tick_i && (period_cnt == 8'd1);
  assign handshake  = (state == PRESENT) && spawn_valid_o && spawn_ready_i;
  assign accept     = rand_ext < RANGE_V;
  assign can_redraw = redraw_cnt < MAX_REDRAW_V;
  // Fold stays in range because GAP_RANGE is at least half of the 5-bit draw space.
  assign offset     = accept ? rand_ext : (rand_ext - RANGE_V);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en_i) state_nxt = COUNT;
      end
      COUNT: begin
        if (!en_i)       state_nxt = IDLE;
        else if (expire) state_nxt = DRAW;
      end
      DRAW: begin
        state_nxt = en_i ? EVAL : IDLE;
      end
      EVAL: begin
        if (!en_i)                       state_nxt = IDLE;
        else if (accept || !can_redraw)  state_nxt = PRESENT;
        else                             state_nxt = DRAW;
      end
      PRESENT: begin
        if (handshake) state_nxt = en_i ? COUNT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Period counter only runs while waiting for a draw or holding a pending spawn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_cnt <= PERIOD_V;
    end else begin
      case (state)
        IDLE: period_cnt <= PERIOD_V;
        COUNT: begin
          if (!en_i)       period_cnt <= PERIOD_V;
          else if (tick_i) period_cnt <= expire ? PERIOD_V : (period_cnt - 8'd1);
        end
        PRESENT: begin
          if (tick_i) period_cnt <= expire ? PERIOD_V : (period_cnt - 8'd1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redraw_cnt <= 8'd0;
    end else if ((state == COUNT) && en_i && expire) begin
      redraw_cnt <= 8'd0;
    end else if ((state == EVAL) && en_i && !accept && can_redraw) begin
      redraw_cnt <= redraw_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spawn_pos_o <= 6'd0;
    end else if ((state == EVAL) && (state_nxt == PRESENT)) begin
      spawn_pos_o <= GAP_MIN_V + offset;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spawn_count_o <= 8'd0;
    end else if (handshake) begin
      spawn_count_o <= spawn_count_o + 8'd1;
    end
  end

  // Registered strobes track the state being entered so they line up with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_o        <= 1'b0;
      spawn_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      next_o        <= (state_nxt == DRAW);
      spawn_valid_o <= (state_nxt == PRESENT);
      overrun_o     <= (state == PRESENT) && expire && !handshake;
    end
  end

endmodule

`default_nettype wire
